// File: rtl/ls_stage_buffer_pkg.sv
// Shared definitions for the load/store sequencing datapath.
// The upstream controller uses phase_t too, so both blocks agree on one encoding.
package ls_pkg;

    localparam int PHASE_W = 2;

    typedef enum logic [PHASE_W-1:0] {
        WAIT  = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2
    } phase_t;

    // Encoding 3 is unused by the controller and is treated as illegal.
    function automatic logic phase_is_illegal(input logic [PHASE_W-1:0] p);
        return (p == 2'd3);
    endfunction

endpackage

// File: rtl/ls_stage_buffer_if.sv
// Valid/ready word stream. The master drives valid and data; the slave drives ready.
interface ls_stage_buffer_if #(
    parameter int WIDTH = 8
);
    logic             valid;
    logic             ready;
    logic [WIDTH-1:0] data;

    modport master (output valid, output data, input  ready);
    modport slave  (input  valid, input  data, output ready);
endinterface

// File: rtl/ls_stage_buffer_fifo_core.sv
// Storage for the stage buffer: memory array, wrapping pointers and occupancy.
// Callers gate push/pop with full/empty; the assertions below catch misuse.
module ls_fifo_core #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;

    // Next pointers and level; flush overrides any transfer in the same cycle.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else if (push_i) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            level_d  = level_q + 1'b1;
        end else if (pop_i) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            level_d  = level_q - 1'b1;
        end
    end

    // Pointer and level registers, cleared asynchronously.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Word storage; contents are intentionally not reset.
    always_ff @(posedge clock) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign level_o = level_q;
    assign full_o  = (level_q == LVL_W'(DEPTH));
    assign empty_o = (level_q == '0);

    // Occupancy must stay within 0..DEPTH; the handshake gating guarantees it.
    always_ff @(posedge clock) begin
        if (resetn) begin
            assert (level_q <= LVL_W'(DEPTH));
            assert (!(push_i && full_o));
            assert (!(pop_i && empty_o));
            assert (!(push_i && pop_i));
        end
    end

endmodule

// File: rtl/ls_stage_buffer.sv
// Stage buffer downstream of the WAIT/LOAD/STORE controller. Fills in LOAD,
// drains in STORE, holds otherwise. Reports batch completion and illegal phases.
module ls_stage_buffer
    import ls_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clock,
    input  logic                   resetn,
    input  logic [PHASE_W-1:0]     phase_i,
    input  logic                   flush_i,
    ls_stage_buffer_if.slave       up_if,
    ls_stage_buffer_if.master      dn_if,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic                   batch_done_o,
    output logic                   phase_err_o
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             is_load, is_store;
    logic             in_ready, out_valid;
    logic             push, pop;
    logic [LVL_W-1:0] level;
    logic             full, empty;
    logic [WIDTH-1:0] rdata;
    logic             batch_done_q, batch_done_d;
    logic             phase_err_q, phase_err_d;

    // Phase 3 decodes as neither LOAD nor STORE, so the stage simply holds.
    assign is_load  = (phase_i == LOAD);
    assign is_store = (phase_i == STORE);

    assign in_ready  = is_load  && !full  && !flush_i;
    assign out_valid = is_store && !empty && !flush_i;
    assign push      = up_if.valid && in_ready;
    assign pop       = out_valid   && dn_if.ready;

    ls_fifo_core #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .resetn  (resetn),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush_i),
        .wdata_i (up_if.data),
        .rdata_o (rdata),
        .level_o (level),
        .full_o  (full),
        .empty_o (empty)
    );

    // A pop from level 1 drains the batch; pop is already low during flush.
    always_comb begin
        batch_done_d = pop && (level == LVL_W'(1));
        phase_err_d  = phase_err_q || phase_is_illegal(phase_i);
    end

    // Status flags: batch_done is a single-cycle pulse, phase_err is sticky.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            batch_done_q <= 1'b0;
            phase_err_q  <= 1'b0;
        end else begin
            batch_done_q <= batch_done_d;
            phase_err_q  <= phase_err_d;
        end
    end

    assign up_if.ready  = in_ready;
    assign dn_if.valid  = out_valid;
    assign dn_if.data   = rdata;
    assign level_o      = level;
    assign full_o       = full;
    assign empty_o      = empty;
    assign batch_done_o = batch_done_q;
    assign phase_err_o  = phase_err_q;

endmodule

// File: tb/tb_ls_stage_buffer.sv
// Directed bench for ls_stage_buffer (WIDTH=8, DEPTH=4) with a queue scoreboard.
module tb_ls_stage_buffer;
    import ls_pkg::*;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clock = 1'b0;
    logic             resetn;
    logic [1:0]       phase;
    logic             flush;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             out_ready;
    logic [2:0]       level;
    logic             full, empty, batch_done, phase_err;

    ls_stage_buffer_if #(.WIDTH(WIDTH)) up_if ();
    ls_stage_buffer_if #(.WIDTH(WIDTH)) dn_if ();

    assign up_if.valid = in_valid;
    assign up_if.data  = in_data;
    assign dn_if.ready = out_ready;

    ls_stage_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clock        (clock),
        .resetn       (resetn),
        .phase_i      (phase),
        .flush_i      (flush),
        .up_if        (up_if),
        .dn_if        (dn_if),
        .level_o      (level),
        .full_o       (full),
        .empty_o      (empty),
        .batch_done_o (batch_done),
        .phase_err_o  (phase_err)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    logic [WIDTH-1:0] sb[$];
    int               mlevel;
    logic             mbatch;
    logic             merr;
    logic             accepted;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        mlevel = 0;
        mbatch = 1'b0;
        merr   = 1'b0;
    endtask

    // One clock with the currently driven inputs: check handshakes before the
    // edge, advance the model at the edge, check registered state after it.
    task automatic cycle();
        logic exp_ir, exp_ov;
        #1;
        exp_ir = (phase == 2'd1) && (mlevel < DEPTH) && !flush;
        exp_ov = (phase == 2'd2) && (mlevel > 0) && !flush;
        chk("in_ready", 32'(up_if.ready), 32'(exp_ir));
        chk("out_valid", 32'(dn_if.valid), 32'(exp_ov));
        if (exp_ov) chk("out_data", 32'(dn_if.data), 32'(sb[0]));
        @(posedge clock);
        accepted = 1'b0;
        mbatch   = 1'b0;
        if (phase == 2'd3) merr = 1'b1;
        if (flush) begin
            sb.delete();
            mlevel = 0;
        end else if (in_valid && exp_ir) begin
            sb.push_back(in_data);
            mlevel++;
            accepted = 1'b1;
        end else if (exp_ov && out_ready) begin
            void'(sb.pop_front());
            mlevel--;
            mbatch = (mlevel == 0);
        end
        @(negedge clock);
        chk("level", 32'(level), 32'(mlevel));
        chk("full", 32'(full), 32'(mlevel == DEPTH));
        chk("empty", 32'(empty), 32'(mlevel == 0));
        chk("batch_done", 32'(batch_done), 32'(mbatch));
        chk("phase_err", 32'(phase_err), 32'(merr));
    endtask

    task automatic set_in(input logic [1:0] ph, input logic fl, input logic iv,
                          input logic [WIDTH-1:0] d, input logic ordy);
        phase     = ph;
        flush     = fl;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
    endtask

    initial begin
        logic [WIDTH-1:0] words[$];
        int idx;

        set_in(2'd0, 1'b0, 1'b1, 8'h00, 1'b0);
        resetn = 1'b0;
        model_reset();
        #12;
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_in_ready", 32'(up_if.ready), 32'd0);
        chk("rst_out_valid", 32'(dn_if.valid), 32'd0);
        chk("rst_phase_err", 32'(phase_err), 32'd0);
        @(negedge clock);
        resetn = 1'b1;

        // WAIT with in_valid held high: nothing moves.
        for (int i = 0; i < 5; i++) cycle();

        // LOAD A1..A5: four accepted, A5 held while full.
        words = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
        idx = 0;
        for (int i = 0; i < 7; i++) begin
            set_in(LOAD, 1'b0, 1'b1, words[idx], 1'b0);
            cycle();
            if (accepted) idx++;
        end
        chk("a5_held_full", 32'(full), 32'd1);
        chk("a5_held_ready", 32'(up_if.ready), 32'd0);

        // STORE: drain A1..A4, then batch_done pulse and idle.
        for (int i = 0; i < 6; i++) begin
            set_in(STORE, 1'b0, 1'b0, 8'h00, 1'b1);
            cycle();
        end

        // Wrap and interleave.
        set_in(LOAD, 1'b0, 1'b1, 8'hB1, 1'b0); cycle();
        set_in(LOAD, 1'b0, 1'b1, 8'hB2, 1'b0); cycle();
        set_in(STORE, 1'b0, 1'b0, 8'h00, 1'b1); cycle();
        set_in(LOAD, 1'b0, 1'b1, 8'hB3, 1'b0); cycle();
        set_in(LOAD, 1'b0, 1'b1, 8'hB4, 1'b0); cycle();
        set_in(LOAD, 1'b0, 1'b1, 8'hB5, 1'b0); cycle();
        // Store with out_ready toggling, including a phase drop with no pop.
        set_in(STORE, 1'b0, 1'b0, 8'h00, 1'b0); cycle();
        set_in(WAIT, 1'b0, 1'b0, 8'h00, 1'b1); cycle();
        for (int i = 0; i < 5; i++) begin
            set_in(STORE, 1'b0, 1'b0, 8'h00, 1'b1);
            cycle();
        end

        // Mid-batch flush with a word offered in the same cycle.
        set_in(LOAD, 1'b0, 1'b1, 8'hC1, 1'b0); cycle();
        set_in(LOAD, 1'b0, 1'b1, 8'hC2, 1'b0); cycle();
        set_in(LOAD, 1'b0, 1'b1, 8'hC3, 1'b0); cycle();
        set_in(LOAD, 1'b1, 1'b1, 8'hC4, 1'b0); cycle();
        set_in(STORE, 1'b0, 1'b0, 8'h00, 1'b1); cycle();
        cycle();

        // Illegal phase behaves as WAIT and latches phase_err.
        set_in(LOAD, 1'b0, 1'b1, 8'hD0, 1'b0); cycle();
        set_in(2'd3, 1'b0, 1'b1, 8'hD1, 1'b1); cycle();
        set_in(WAIT, 1'b0, 1'b1, 8'hD2, 1'b0); cycle();
        cycle();

        // Drain D0 so batch_done is high, then reset asynchronously mid-cycle.
        set_in(STORE, 1'b0, 1'b0, 8'h00, 1'b1); cycle();
        chk("pre_rst_batch", 32'(batch_done), 32'd1);
        #2;
        resetn = 1'b0;
        #1;
        chk("async_batch", 32'(batch_done), 32'd0);
        chk("async_err", 32'(phase_err), 32'd0);
        chk("async_level", 32'(level), 32'd0);
        model_reset();
        @(negedge clock);
        resetn = 1'b1;

        // Reset with words in flight: everything is discarded.
        set_in(LOAD, 1'b0, 1'b1, 8'hE1, 1'b0); cycle();
        set_in(LOAD, 1'b0, 1'b1, 8'hE2, 1'b0); cycle();
        #2;
        resetn = 1'b0;
        #1;
        chk("async_level2", 32'(level), 32'd0);
        chk("async_empty2", 32'(empty), 32'd1);
        model_reset();
        @(negedge clock);
        resetn = 1'b1;
        set_in(STORE, 1'b0, 1'b0, 8'h00, 1'b1); cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ls_stage_buffer.md
Name: ls_stage_buffer

Overview:
- Datapath stage directly downstream of the WAIT/LOAD/STORE sequencing controller; consumes its current phase.
- In LOAD, accepts words from an upstream valid/ready stream into a DEPTH-entry FIFO.
- In STORE, drains the FIFO to a downstream valid/ready stream.
- In WAIT, holds contents; no transfers. Reports level, batch completion and illegal phase encodings.

Parameters:
- WIDTH, 8, data word width in bits (>=1).
- DEPTH, 4, FIFO entries; power of 2, >=2.

Ports:
- clock  input  1  rising-edge clock.
- resetn  input  1  asynchronous, active-low reset.
- phase  input  2  controller state (phase_t): WAIT=0, LOAD=1, STORE=2; 3 is illegal.
- flush  input  1  synchronous clear of FIFO pointers and level.
- in_valid  input  1  upstream word valid.
- in_data  input  WIDTH  upstream word.
- in_ready  output  1  stage accepts word this cycle.
- out_valid  output  1  word available to downstream.
- out_data  output  WIDTH  head-of-FIFO word.
- out_ready  input  1  downstream accepts word.
- level  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- full  output  1  level==DEPTH.
- empty  output  1  level==0.
- batch_done  output  1  one-cycle pulse, registered.
- phase_err  output  1  sticky illegal-phase flag.

Behaviour:
- Reset is resetn, asynchronous, active-low; clock is clock.
- Reset values:
  - Pointers, level and batch_done = 0; phase_err = 0.
  - empty = 1, full = 0, in_ready = 0, out_valid = 0.
  - out_data is don't-care; memory contents are not reset.
- Handshakes (all combinational from registered state and current inputs):
  - in_ready = (phase==LOAD) && !full && !flush.
  - out_valid = (phase==STORE) && !empty && !flush.
  - Push happens when in_valid && in_ready; pop happens when out_valid && out_ready.
  - Push and pop are never simultaneous, since phases are exclusive.
- out_data = mem[rd_ptr], read combinationally. A word pushed at edge N is visible on out_data from cycle N+1 when the phase is STORE. Minimum push-to-pop latency is 1 cycle.
- Pointers are log2(DEPTH) bits wide and wrap naturally: DEPTH-1 -> 0.
- level: +1 on push, -1 on pop. It never exceeds DEPTH and never underflows; this follows from the ready/valid gating, and an assertion must check it.
- Phase changes:
  - Leaving STORE drops out_valid immediately, even without a pop. Downstream must tolerate withdrawal; no transfer is counted in that cycle.
  - Leaving LOAD drops in_ready immediately; upstream holds its word.
- flush: at the next edge, rd_ptr, wr_ptr and level go to 0 and batch_done to 0. Flush wins over any handshake in the same cycle; ready/valid are already low.
- batch_done: registered. It is 1 for exactly the cycle after a pop that takes level from 1 to 0 in STORE; otherwise 0.
- phase_err: set at an edge where phase==3 and cleared only by reset. While phase==3 the stage behaves as WAIT (no transfers, contents held).
- Full in LOAD: in_ready low and upstream stalls; no overwrite, no data loss.
- Empty in STORE: out_valid low; the stage idles until the phase changes.
- Reset mid-transfer: state clears immediately and asynchronously. Any word in flight is lost, with no partial state.

Decomposition:
- Shared package ls_pkg:
  - typedef enum logic [1:0] phase_t {WAIT=2'd0, LOAD=2'd1, STORE=2'd2}.
  - Localparam PHASE_W=2.
- The upstream controller's state type migrates to phase_t so both blocks share one encoding.
- One sub-module, ls_fifo_core: memory array, rd/wr pointers, level counter, full/empty; push/pop/flush inputs.
- ls_stage_buffer holds the phase decode, handshake gating, batch_done and phase_err.

Test Plan (WIDTH=8, DEPTH=4):
- Reset then WAIT with in_valid=1 → in_ready=0, out_valid=0, level=0, empty=1 for 5 cycles.
- LOAD with in_valid=1, data A1,A2,A3,A4,A5 → first four accepted on consecutive edges, full=1, level=4, in_ready=0. A5 is held, not accepted.
- STORE with out_ready=1 → out_data A1,A2,A3,A4 on consecutive cycles, level 4→0. batch_done=1 for exactly the cycle after A4 is popped; out_valid=0 afterwards.
- Wrap and interleave: LOAD B1,B2; STORE pop 1 (B1); LOAD B3,B4,B5; STORE → B2,B3,B4,B5 in order, wrapping pointer index 3→0.
- Mid-flush: LOAD C1,C2,C3 (level=3), then flush=1 for one cycle with in_valid=1 → level=0, empty=1, C4 not accepted. In STORE, out_valid stays 0.
- phase=3 for one cycle with in_valid=1 → no push, phase_err=1 from the next cycle and stays set. resetn=0 asynchronously clears phase_err, level and batch_done without waiting for a clock edge.
